// File: rtl/reglk_ctrl.sv
// reglk_ctrl: sticky lock-word array with SW/DBG round-robin writes and a JTAG key-unlock FSM.
module reglk_ctrl #(
  parameter int          NUM_WORDS  = 6,
  parameter int          WORD_W     = 32,
  parameter logic [31:0] UNLOCK_KEY = 32'hA5C3_5A3C,
  parameter int          MAX_TRIES  = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_low,
  input  logic                        sw_req_i,
  input  logic [2:0]                  sw_idx_i,
  input  logic [WORD_W-1:0]           sw_wdata_i,
  output logic                        sw_gnt_o,
  output logic                        sw_err_o,
  input  logic                        dbg_req_i,
  input  logic [2:0]                  dbg_idx_i,
  input  logic [WORD_W-1:0]           dbg_wdata_i,
  output logic                        dbg_gnt_o,
  output logic                        dbg_err_o,
  input  logic                        jtag_key_valid_i,
  input  logic [31:0]                 jtag_key_i,
  input  logic                        jtag_relock_i,
  output logic                        jtag_unlocked_o,
  output logic                        lockout_o,
  output logic [NUM_WORDS*WORD_W-1:0] reglk_o
);
  typedef enum logic [1:0] {LOCKED, CHECK, UNLOCKED, LOCKOUT} state_t;
  state_t                             state;
  logic [NUM_WORDS-1:0][WORD_W-1:0]   words;
  logic [31:0]                        key_q;
  logic [2:0]                         tries;
  logic                               rr;
  logic                               sw_v, dbg_v, sel_sw, sel_dbg, sw_ok, dbg_ok, try_last;
  assign reglk_o = words;
  // rr=0 gives SW priority; a port in its response cycle is not eligible
  always_comb begin
    sw_v     = sw_req_i & ~sw_gnt_o & ~sw_err_o;
    dbg_v    = dbg_req_i & ~dbg_gnt_o & ~dbg_err_o;
    sel_sw   = sw_v & (~dbg_v | ~rr);
    sel_dbg  = dbg_v & ~sel_sw;
    sw_ok    = (32'(sw_idx_i) < NUM_WORDS) && !words[NUM_WORDS-1][0];
    dbg_ok   = (32'(dbg_idx_i) < NUM_WORDS) && state == UNLOCKED;
    try_last = 32'(tries) + 32'd1 == 32'(MAX_TRIES);
  end
  always_ff @(posedge clk_i or negedge rst_low) begin
    if (!rst_low) begin
      words           <= '0;
      state           <= LOCKED;
      key_q           <= '0;
      tries           <= '0;
      rr              <= 1'b0;
      sw_gnt_o        <= 1'b0;
      sw_err_o        <= 1'b0;
      dbg_gnt_o       <= 1'b0;
      dbg_err_o       <= 1'b0;
      jtag_unlocked_o <= 1'b0;
      lockout_o       <= 1'b0;
    end else begin
      sw_gnt_o  <= sel_sw & sw_ok;
      sw_err_o  <= sel_sw & ~sw_ok;
      dbg_gnt_o <= sel_dbg & dbg_ok;
      dbg_err_o <= sel_dbg & ~dbg_ok;
      if (sel_sw | sel_dbg) rr <= sel_sw;
      if (sel_sw && sw_ok) words[sw_idx_i] <= words[sw_idx_i] | sw_wdata_i;
      if (sel_dbg && dbg_ok) words[dbg_idx_i] <= dbg_wdata_i;
      case (state)
        LOCKED: if (jtag_key_valid_i) begin
          state <= CHECK;
          key_q <= jtag_key_i;
        end
        CHECK: if (key_q == UNLOCK_KEY) begin
          state           <= UNLOCKED;
          tries           <= '0;
          jtag_unlocked_o <= 1'b1;
        end else begin
          tries     <= tries + 3'd1;
          state     <= try_last ? LOCKOUT : LOCKED;
          lockout_o <= try_last;
        end
        UNLOCKED: if (jtag_relock_i) begin
          state           <= LOCKED;
          jtag_unlocked_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
